// File: rtl/multi_cycle_proc_ls.sv
// Multi-cycle in-order core, one instruction in flight: FETCH -> EXEC -> (MEM_REQ -> MEM_WAIT) -> WB.
// Latency: JUMP 2, ARITH 3, STORE 3, LOAD 4 + response latency cycles (all ready inputs high).
// Backpressure: any __RDY low holds the current state; every latched field stays stable while stalled.
//
// Ports:
//   CLK, nRST                       clock, asynchronous active-low reset
//   pgm_read_pc / pgm_read*         instruction fetch address, word and valid
//   dec_inst / dec_*                instruction to decoder (combinational), decoded fields back
//   rf_read*/rf_write*              two register read ports, one write port
//   exec_basicExec*                 ALU operands out, packed {data, addr, nextPC} result in
//   dmem_request*/dmem_response*    data memory request (load/store) and load response
//   instret                         retired-instruction counter, present only when
//                                   MULTI_CYCLE_PROC_INSTRET_EN is defined
module multi_cycle_proc_ls #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    REG_ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic                      CLK,
    input  logic                      nRST,
    // program memory and decoder
    output logic [DATA_WIDTH-1:0]     pgm_read_pc,
    input  logic [DATA_WIDTH-1:0]     pgm_read,
    input  logic                      pgm_read__RDY,
    output logic [DATA_WIDTH-1:0]     dec_inst,
    input  logic [1:0]                dec_op,
    input  logic [3:0]                dec_arithOp,
    input  logic [REG_ADDR_WIDTH-1:0] dec_src1,
    input  logic [REG_ADDR_WIDTH-1:0] dec_src2,
    input  logic [REG_ADDR_WIDTH-1:0] dec_dst,
    input  logic                      dec__RDY,
    // register file
    output logic [REG_ADDR_WIDTH-1:0] rf_read1_regnum,
    output logic [REG_ADDR_WIDTH-1:0] rf_read2_regnum,
    input  logic [DATA_WIDTH-1:0]     rf_read1,
    input  logic [DATA_WIDTH-1:0]     rf_read2,
    input  logic                      rf_read__RDY,
    output logic                      rf_write__ENA,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_regnum,
    output logic [DATA_WIDTH-1:0]     rf_write_regval,
    input  logic                      rf_write__RDY,
    // execute unit
    output logic [3:0]                exec_basicExec_op,
    output logic [DATA_WIDTH-1:0]     exec_basicExec_src1,
    output logic [DATA_WIDTH-1:0]     exec_basicExec_src2,
    input  logic [3*DATA_WIDTH-1:0]   exec_basicExec,
    input  logic                      exec_basicExec__RDY,
    // data memory
    output logic                      dmem_request__ENA,
    output logic                      dmem_request_write_en,
    output logic [DATA_WIDTH-1:0]     dmem_request_addr,
    output logic [DATA_WIDTH-1:0]     dmem_request_data,
    input  logic                      dmem_request__RDY,
    input  logic                      dmem_response__ENA,
    input  logic [DATA_WIDTH-1:0]     dmem_response
`ifdef MULTI_CYCLE_PROC_INSTRET_EN
    ,
    output logic [31:0]               instret
`endif
);

    // Instruction classes as produced by the decoder.
    localparam logic [1:0] OP_ARITH = 2'd0;
    localparam logic [1:0] OP_LOAD  = 2'd1;
    localparam logic [1:0] OP_STORE = 2'd2;
    localparam logic [1:0] OP_JUMP  = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_EXEC     = 3'd1,
        S_MEM_REQ  = 3'd2,
        S_MEM_WAIT = 3'd3,
        S_WB       = 3'd4
    } state_t;

    // Execute-unit result, nextPC in the least significant bits.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] next_pc;
    } exec_res_t;

    state_t                    state_q;
    state_t                    state_d;
    exec_res_t                 exec_res;

    logic [DATA_WIDTH-1:0]     pc_q;
    logic [1:0]                op_q;
    logic [3:0]                arith_op_q;
    logic [REG_ADDR_WIDTH-1:0] src1_q;
    logic [REG_ADDR_WIDTH-1:0] src2_q;
    logic [REG_ADDR_WIDTH-1:0] dst_q;
    // data_q holds the ALU result and is overwritten by the load response,
    // so it is always the value written back in WB.
    logic [DATA_WIDTH-1:0]     data_q;
    logic [DATA_WIDTH-1:0]     addr_q;
    logic [DATA_WIDTH-1:0]     next_pc_q;
    logic [DATA_WIDTH-1:0]     store_dat_q;

    logic                      fetch_ld;
    logic                      exec_ld;
    logic                      resp_ld;
    logic                      retire;
    logic                      dst_is_zero;

    assign exec_res    = exec_basicExec;
    assign dst_is_zero = (dst_q == '0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and load-enable logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        fetch_ld = 1'b0;
        exec_ld  = 1'b0;
        resp_ld  = 1'b0;
        retire   = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (pgm_read__RDY && dec__RDY) begin
                    fetch_ld = 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (rf_read__RDY && exec_basicExec__RDY) begin
                    exec_ld = 1'b1;
                    case (op_q)
                        OP_ARITH: state_d = S_WB;
                        OP_LOAD,
                        OP_STORE: state_d = S_MEM_REQ;
                        default: begin
                            // JUMP retires straight out of EXEC.
                            state_d = S_FETCH;
                            retire  = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM_REQ: begin
                if (dmem_request__RDY) begin
                    if (op_q == OP_STORE) begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_MEM_WAIT;
                    end
                end
            end
            S_MEM_WAIT: begin
                if (dmem_response__ENA) begin
                    resp_ld = 1'b1;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                // A write to x0 is suppressed and needs no handshake.
                if (dst_is_zero || rf_write__RDY) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Program counter: on a JUMP the nextPC is taken directly from the
    // execute result because it is being latched on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= RESET_PC;
        end else if (retire) begin
            pc_q <= (state_q == S_EXEC) ? exec_res.next_pc : next_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Decoded-field latches
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            op_q       <= '0;
            arith_op_q <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            dst_q      <= '0;
        end else if (fetch_ld) begin
            op_q       <= dec_op;
            arith_op_q <= dec_arithOp;
            src1_q     <= dec_src1;
            src2_q     <= dec_src2;
            dst_q      <= dec_dst;
        end
    end

    // ------------------------------------------------------------------
    // Execute-result and memory-data latches
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            data_q      <= '0;
            addr_q      <= '0;
            next_pc_q   <= '0;
            store_dat_q <= '0;
        end else if (exec_ld) begin
            data_q      <= exec_res.data;
            addr_q      <= exec_res.addr;
            next_pc_q   <= exec_res.next_pc;
            store_dat_q <= rf_read2;
        end else if (resp_ld) begin
            data_q      <= dmem_response;
        end
    end

`ifdef MULTI_CYCLE_PROC_INSTRET_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            instret <= '0;
        end else if (retire) begin
            instret <= instret + 32'd1;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs: registered state or pure functions of it, except the
    // decoder and ALU operand paths which are direct pass-throughs.
    // ------------------------------------------------------------------
    assign pgm_read_pc           = pc_q;
    assign dec_inst              = pgm_read;

    assign rf_read1_regnum       = src1_q;
    assign rf_read2_regnum       = src2_q;
    assign rf_write__ENA         = (state_q == S_WB) && !dst_is_zero;
    assign rf_write_regnum       = dst_q;
    assign rf_write_regval       = data_q;

    assign exec_basicExec_op     = arith_op_q;
    assign exec_basicExec_src1   = rf_read1;
    assign exec_basicExec_src2   = rf_read2;

    assign dmem_request__ENA     = (state_q == S_MEM_REQ);
    assign dmem_request_write_en = (state_q == S_MEM_REQ) && (op_q == OP_STORE);
    assign dmem_request_addr     = addr_q;
    assign dmem_request_data     = store_dat_q;

endmodule

// File: tb/tb_multi_cycle_proc_ls.sv
// Testbench for multi_cycle_proc_ls: the bench plays program memory, decoder,
// register file, execute unit and data memory, and checks each instruction's
// externally visible effects against a per-instruction reference model.
module tb_multi_cycle_proc_ls;

    localparam logic [31:0] RPC    = 32'h100;
    localparam int          BUDGET = 80;

    localparam logic [1:0] ARITH = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] STORE = 2'd2;
    localparam logic [1:0] JUMP  = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_o;
    logic [31:0] pgm_word;
    logic        pgm_rdy;
    logic [31:0] dec_inst;
    logic [1:0]  dec_op;
    logic [3:0]  dec_aop;
    logic [4:0]  dec_s1, dec_s2, dec_dst;
    logic        dec_rdy;
    logic [4:0]  rf_r1n, rf_r2n;
    logic [31:0] rf_r1, rf_r2;
    logic        rf_rrdy;
    logic        rf_wena;
    logic [4:0]  rf_wn;
    logic [31:0] rf_wv;
    logic        rf_wrdy;
    logic [3:0]  ex_op;
    logic [31:0] ex_s1, ex_s2;
    logic [95:0] ex_res;
    logic        ex_rdy;
    logic        dm_ena, dm_we;
    logic [31:0] dm_addr, dm_data;
    logic        dm_rdy;
    logic        dm_rena;
    logic [31:0] dm_resp;
`ifdef MULTI_CYCLE_PROC_INSTRET_EN
    logic [31:0] instret;
    logic [31:0] exp_instret;
`endif

    int checks;
    int errors;
    logic [31:0] exp_pc;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  aop;
        logic [4:0]  s1, s2, dst;
        logic [31:0] rf1, rf2, xdata, xaddr, xnpc, resp;
        int          ex_st, req_st, wr_st, lat;
        int          e_cyc;
        bit          e_wr;
        logic [31:0] e_wval;
        bit          e_req;
        bit          e_we;
        logic [31:0] e_pc;
    } vec_t;

    multi_cycle_proc_ls #(
        .DATA_WIDTH    (32),
        .REG_ADDR_WIDTH(5),
        .RESET_PC      (RPC)
    ) dut (
        .CLK                  (clk),
        .nRST                 (rst_n),
        .pgm_read_pc          (pc_o),
        .pgm_read             (pgm_word),
        .pgm_read__RDY        (pgm_rdy),
        .dec_inst             (dec_inst),
        .dec_op               (dec_op),
        .dec_arithOp          (dec_aop),
        .dec_src1             (dec_s1),
        .dec_src2             (dec_s2),
        .dec_dst              (dec_dst),
        .dec__RDY             (dec_rdy),
        .rf_read1_regnum      (rf_r1n),
        .rf_read2_regnum      (rf_r2n),
        .rf_read1             (rf_r1),
        .rf_read2             (rf_r2),
        .rf_read__RDY         (rf_rrdy),
        .rf_write__ENA        (rf_wena),
        .rf_write_regnum      (rf_wn),
        .rf_write_regval      (rf_wv),
        .rf_write__RDY        (rf_wrdy),
        .exec_basicExec_op    (ex_op),
        .exec_basicExec_src1  (ex_s1),
        .exec_basicExec_src2  (ex_s2),
        .exec_basicExec       (ex_res),
        .exec_basicExec__RDY  (ex_rdy),
        .dmem_request__ENA    (dm_ena),
        .dmem_request_write_en(dm_we),
        .dmem_request_addr    (dm_addr),
        .dmem_request_data    (dm_data),
        .dmem_request__RDY    (dm_rdy),
        .dmem_response__ENA   (dm_rena),
        .dmem_response        (dm_resp)
`ifdef MULTI_CYCLE_PROC_INSTRET_EN
        ,
        .instret              (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic [1:0] op, input logic [3:0] aop, input logic [4:0] s1, input logic [4:0] s2,
        input logic [4:0] dst, input logic [31:0] rf1, input logic [31:0] rf2,
        input logic [31:0] xdata, input logic [31:0] xaddr, input logic [31:0] xnpc,
        input logic [31:0] resp, input int ex_st, input int req_st, input int wr_st, input int lat,
        input int e_cyc, input bit e_wr, input logic [31:0] e_wval, input bit e_req,
        input bit e_we, input logic [31:0] e_pc);
        vec_t v;
        v.op = op; v.aop = aop; v.s1 = s1; v.s2 = s2; v.dst = dst;
        v.rf1 = rf1; v.rf2 = rf2; v.xdata = xdata; v.xaddr = xaddr; v.xnpc = xnpc; v.resp = resp;
        v.ex_st = ex_st; v.req_st = req_st; v.wr_st = wr_st; v.lat = lat;
        v.e_cyc = e_cyc; v.e_wr = e_wr; v.e_wval = e_wval; v.e_req = e_req; v.e_we = e_we; v.e_pc = e_pc;
        return v;
    endfunction

    // Reference model: an instruction's architectural effects and its cycle
    // cost, derived from its class and the stall pattern the bench applies.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        r        = v;
        r.e_pc   = v.xnpc;
        r.e_req  = (v.op == LOAD) || (v.op == STORE);
        r.e_we   = (v.op == STORE);
        r.e_wr   = ((v.op == ARITH) || (v.op == LOAD)) && (v.dst != 0);
        r.e_wval = (v.op == LOAD) ? v.resp : v.xdata;
        case (v.op)
            JUMP:    r.e_cyc = 2;
            ARITH:   r.e_cyc = 3;
            STORE:   r.e_cyc = 3;
            default: r.e_cyc = 4 + v.lat;
        endcase
        r.e_cyc += v.ex_st;
        if (r.e_req) r.e_cyc += v.req_st;
        if (r.e_wr)  r.e_cyc += v.wr_st;
        return r;
    endfunction

    // Runs one instruction from FETCH to retire; called just after a negedge.
    task automatic run(input vec_t v, input string nm);
        int cnt = 0, ex_left, req_left, wr_left, resp_cd = 0;
        int wr_cnt = 0, req_cnt = 0, req_ena_cyc = 0;
        logic [31:0] wn = '0, wv = '0, raddr = '0, rdata = '0;
        logic rwe = 1'b0;
        bit done = 0;
        logic [31:0] start_pc;
        start_pc = pc_o;
        dec_op = v.op; dec_aop = v.aop; dec_s1 = v.s1; dec_s2 = v.s2; dec_dst = v.dst;
        rf_r1 = v.rf1; rf_r2 = v.rf2;
        ex_res = {v.xdata, v.xaddr, v.xnpc};
        dm_resp = v.resp; dm_rena = 1'b0; dm_rdy = 1'b0; rf_wrdy = 1'b0;
        pgm_word = $urandom; pgm_rdy = 1'b1; dec_rdy = 1'b1;
        ex_left = v.ex_st; req_left = v.req_st; wr_left = v.wr_st;
        rf_rrdy = 1'b1; ex_rdy = 1'b1;
        if (ex_left > 0) begin
            if (v.ex_st % 2 == 1) rf_rrdy = 1'b0; else ex_rdy = 1'b0;
        end
        #1 chk({nm, " dec_inst"}, dec_inst, pgm_word);
        while (!done) begin
            @(posedge clk);
            cnt++;
            if (cnt == 1) begin
                #1; pgm_rdy = 1'b0; dec_rdy = 1'b0;
            end
            @(negedge clk);
            dm_rena = 1'b0;
            if (resp_cd > 0) begin
                resp_cd--;
                if (resp_cd == 0) dm_rena = 1'b1;
            end
            if (ex_left > 0) ex_left--;
            else begin rf_rrdy = 1'b1; ex_rdy = 1'b1; end
            if (dm_ena) begin
                req_ena_cyc++;
                if (req_left > 0) begin dm_rdy = 1'b0; req_left--; end
                else begin
                    dm_rdy = 1'b1; req_cnt++;
                    raddr = dm_addr; rdata = dm_data; rwe = dm_we;
                    if (v.op == LOAD) resp_cd = v.lat;
                end
            end else dm_rdy = 1'b0;
            if (rf_wena) begin
                if (wr_left > 0) begin rf_wrdy = 1'b0; wr_left--; end
                else begin rf_wrdy = 1'b1; wr_cnt++; wn = 32'(rf_wn); wv = rf_wv; end
            end else rf_wrdy = 1'b0;
            if (pc_o != start_pc) done = 1;
            else if (cnt >= BUDGET) begin
                errors++;
                $display("FAIL %s timeout: no retire after %0d cycles", nm, cnt);
                done = 1;
            end
        end
        dm_rena = 1'b0; dm_rdy = 1'b0; rf_wrdy = 1'b0;
        chk({nm, " cycles"}, cnt, v.e_cyc);
        chk({nm, " pc"}, pc_o, v.e_pc);
        chk({nm, " rf_writes"}, wr_cnt, {31'd0, v.e_wr});
        if (v.e_wr) begin
            chk({nm, " wr_regnum"}, wn, 32'(v.dst));
            chk({nm, " wr_regval"}, wv, v.e_wval);
        end
        chk({nm, " dmem_reqs"}, req_cnt, {31'd0, v.e_req});
        chk({nm, " dmem_ena_cycles"}, req_ena_cyc, v.e_req ? 1 + v.req_st : 0);
        if (v.e_req) begin
            chk({nm, " dmem_addr"}, raddr, v.xaddr);
            chk({nm, " dmem_we"}, {31'd0, rwe}, {31'd0, v.e_we});
            if (v.e_we) chk({nm, " dmem_data"}, rdata, v.rf2);
        end
        chk({nm, " rd1_regnum"}, 32'(rf_r1n), 32'(v.s1));
        chk({nm, " rd2_regnum"}, 32'(rf_r2n), 32'(v.s2));
        chk({nm, " exec_op"}, 32'(ex_op), 32'(v.aop));
        chk({nm, " exec_src2"}, ex_s2, v.rf2);
`ifdef MULTI_CYCLE_PROC_INSTRET_EN
        exp_instret++;
        chk({nm, " instret"}, instret, exp_instret);
`endif
        exp_pc = v.e_pc;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " pc"}, pc_o, RPC);
        chk({nm, " dmem_ena"}, {31'd0, dm_ena}, 32'd0);
        chk({nm, " write_en"}, {31'd0, dm_we}, 32'd0);
        chk({nm, " rf_wena"}, {31'd0, rf_wena}, 32'd0);
        chk({nm, " rd1_regnum"}, 32'(rf_r1n), 32'd0);
        chk({nm, " wr_regval"}, rf_wv, 32'd0);
        chk({nm, " dmem_addr"}, dm_addr, 32'd0);
        chk({nm, " dmem_data"}, dm_data, 32'd0);
        chk({nm, " exec_op"}, 32'(ex_op), 32'd0);
`ifdef MULTI_CYCLE_PROC_INSTRET_EN
        chk({nm, " instret"}, instret, 32'd0);
`endif
    endtask

    vec_t tbl[8];

    initial begin
        vec_t v;
        int ena_seen;
        int guard;
        checks = 0; errors = 0;
        rst_n = 1'b0;
        pgm_word = '0; pgm_rdy = 1'b0; dec_op = '0; dec_aop = '0; dec_s1 = '0; dec_s2 = '0;
        dec_dst = '0; dec_rdy = 1'b0; rf_r1 = '0; rf_r2 = '0; rf_rrdy = 1'b0; rf_wrdy = 1'b0;
        ex_res = '0; ex_rdy = 1'b0; dm_rdy = 1'b0; dm_rena = 1'b0; dm_resp = '0;
`ifdef MULTI_CYCLE_PROC_INSTRET_EN
        exp_instret = '0;
`endif
        // Directed vectors: op aop s1 s2 dst rf1 rf2 xdata xaddr xnpc resp ex req wr lat | cyc wr wval req we pc
        tbl[0] = mkv(ARITH, 4'h5, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h55, 32'h0, 32'h104, 32'h0,
                     0, 0, 0, 1, 3, 1, 32'h55, 0, 0, 32'h104);
        tbl[1] = mkv(LOAD, 4'h0, 5'd4, 5'd5, 5'd7, 32'h1, 32'h2, 32'h999, 32'h40, 32'h108, 32'hDEAD,
                     0, 0, 0, 5, 9, 1, 32'hDEAD, 1, 0, 32'h108);
        tbl[2] = mkv(STORE, 4'h1, 5'd6, 5'd4, 5'd9, 32'h3, 32'h77, 32'h0, 32'h80, 32'h10C, 32'h0,
                     0, 3, 0, 1, 6, 0, 32'h0, 1, 1, 32'h10C);
        tbl[3] = mkv(ARITH, 4'h2, 5'd1, 5'd1, 5'd0, 32'h5, 32'h6, 32'h1234, 32'h0, 32'h110, 32'h0,
                     0, 0, 2, 1, 3, 0, 32'h0, 0, 0, 32'h110);
        tbl[4] = mkv(JUMP, 4'h3, 5'd2, 5'd3, 5'd5, 32'h7, 32'h8, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0,
                     0, 0, 0, 1, 2, 0, 32'h0, 0, 0, 32'hFFFF_FFFC);
        tbl[5] = mkv(ARITH, 4'h4, 5'd8, 5'd9, 5'd6, 32'h9, 32'hA, 32'hA5A5, 32'h0, 32'h0, 32'h0,
                     0, 0, 0, 1, 3, 1, 32'hA5A5, 0, 0, 32'h0);
        tbl[6] = mkv(LOAD, 4'h6, 5'd10, 5'd11, 5'd0, 32'hB, 32'hC, 32'h0, 32'h44, 32'h20, 32'hBEEF,
                     2, 1, 0, 1, 8, 0, 32'h0, 1, 0, 32'h20);
        tbl[7] = mkv(ARITH, 4'h7, 5'd12, 5'd13, 5'd31, 32'hD, 32'hE, 32'hC0DE, 32'h0, 32'h24, 32'h0,
                     1, 0, 2, 1, 6, 1, 32'hC0DE, 0, 0, 32'h24);

        repeat (2) @(negedge clk);
        chk_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("after_reset");
        exp_pc = RPC;

        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Stray response while idle in FETCH must change nothing.
        dm_resp = 32'hBAD0_BAD0; dm_rena = 1'b1;
        @(negedge clk);
        dm_rena = 1'b0;
        @(negedge clk);
        chk("stray pc", pc_o, exp_pc);
        chk("stray dmem_ena", {31'd0, dm_ena}, 32'd0);
        chk("stray rf_wena", {31'd0, rf_wena}, 32'd0);
        v = model(mkv(ARITH, 4'h9, 5'd3, 5'd4, 5'd2, 32'h1, 32'h2, 32'h3131, 32'h0, exp_pc + 32'd4,
                      32'h0, 0, 0, 0, 1, 0, 0, 32'h0, 0, 0, 32'h0));
        run(v, "post_stray");

        // Randomized instruction stream against the reference model.
        for (int i = 0; i < 40; i++) begin
            v.op = 2'($urandom_range(0, 3));
            v.aop = 4'($urandom); v.s1 = 5'($urandom); v.s2 = 5'($urandom);
            v.dst = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            v.rf1 = $urandom; v.rf2 = $urandom; v.xdata = $urandom; v.xaddr = $urandom;
            v.resp = $urandom;
            v.xnpc = (v.op == JUMP) ? $urandom : exp_pc + 32'd4;
            if (v.xnpc == exp_pc) v.xnpc = v.xnpc ^ 32'h1;
            v.ex_st = $urandom_range(0, 2); v.req_st = $urandom_range(0, 3);
            v.wr_st = $urandom_range(0, 3); v.lat = $urandom_range(1, 4);
            run(model(v), $sformatf("rnd%0d", i));
        end

        // Reset pulsed while a load waits for its response.
        dec_op = LOAD; dec_aop = 4'h1; dec_s1 = 5'd1; dec_s2 = 5'd2; dec_dst = 5'd3;
        ex_res = {32'h1, 32'h60, exp_pc + 32'd4}; rf_rrdy = 1'b1; ex_rdy = 1'b1;
        pgm_rdy = 1'b1; dec_rdy = 1'b1;
        @(posedge clk);
        #1; pgm_rdy = 1'b0; dec_rdy = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!dm_ena && guard < BUDGET);
        chk("abort req_seen", {31'd0, dm_ena}, 32'd1);
        dm_rdy = 1'b1;
        @(negedge clk);
        dm_rdy = 1'b0;
        chk("abort in_mem_wait ena", {31'd0, dm_ena}, 32'd0);
        #1 rst_n = 1'b0;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
`ifdef MULTI_CYCLE_PROC_INSTRET_EN
        exp_instret = '0;
`endif
        dm_resp = 32'h5555_AAAA; dm_rena = 1'b1;
        ena_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            dm_rena = 1'b0;
            if (dm_ena || rf_wena) ena_seen++;
        end
        chk("abort no_reissue", ena_seen, 0);
        chk("abort pc_hold", pc_o, RPC);
        exp_pc = RPC;
        v = model(mkv(ARITH, 4'hA, 5'd7, 5'd8, 5'd4, 32'h1, 32'h2, 32'h4242, 32'h0, RPC + 32'd4,
                      32'h0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 0, 32'h0));
        run(v, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_cycle_proc_ls.md
# multi_cycle_proc_ls

- Parametrised successor of the three-rule multi-cycle core: one instruction in flight through fetch/decode, execute, memory and writeback.
- Adds configurable data and register-index widths, two register-file read ports, and real load/store traffic on the dmem request/response channel.
- Adds PC advance for every instruction class and an `x0` write-suppression rule.
- Sits between the program memory, decoder, register file, execute unit and data memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of PC, instruction, operands, addresses and data
- `REG_ADDR_WIDTH`, 5, register index width
- `RESET_PC`, 0, PC value loaded at reset

Ports:
- Clock and reset (one clock; reset is asynchronous and active-low):
  - `CLK` in 1 clock
  - `nRST` in 1 reset
- Program memory and decoder:
  - `pgm$read$pc` out DATA_WIDTH, fetch address (= `pc`)
  - `pgm$read` in DATA_WIDTH, instruction word
  - `pgm$read__RDY` in 1, instruction valid
  - `dec$inst` out DATA_WIDTH, = `pgm$read` (combinational)
  - `dec$op` in 2, instruction class: 0 ARITH, 1 LOAD, 2 STORE, 3 JUMP
  - `dec$arithOp` in 4, ALU function
  - `dec$src1` in REG_ADDR_WIDTH
  - `dec$src2` in REG_ADDR_WIDTH
  - `dec$dst` in REG_ADDR_WIDTH
  - `dec__RDY` in 1, decoder fields valid
- Register file:
  - `rf$read1$regnum` out REG_ADDR_WIDTH
  - `rf$read2$regnum` out REG_ADDR_WIDTH
  - `rf$read1` in DATA_WIDTH
  - `rf$read2` in DATA_WIDTH
  - `rf$read__RDY` in 1
  - `rf$write__ENA` out 1
  - `rf$write$regnum` out REG_ADDR_WIDTH
  - `rf$write$regval` out DATA_WIDTH
  - `rf$write__RDY` in 1
- Execute unit:
  - `exec$basicExec$op` out 4
  - `exec$basicExec$src1` out DATA_WIDTH
  - `exec$basicExec$src2` out DATA_WIDTH
  - `exec$basicExec` in 3*DATA_WIDTH, packed {data, addr, nextPC}, nextPC in the LSBs
  - `exec$basicExec__RDY` in 1
- Data memory:
  - `dmem$request__ENA` out 1
  - `dmem$request$write_en` out 1
  - `dmem$request$addr` out DATA_WIDTH
  - `dmem$request$data` out DATA_WIDTH
  - `dmem$request__RDY` in 1
  - `dmem$response__ENA` in 1
  - `dmem$response` in DATA_WIDTH

## Operation
States: FETCH, EXEC, MEM_REQ, MEM_WAIT, WB.

Datapath drive rules:
- `rf$read1/2$regnum` are driven from the latched `src1`/`src2`.
- `exec$basicExec$op/src1/src2` are driven from the latched `arithOp`, `rf$read1` and `rf$read2`.
- All outputs are registered or a pure function of registered state. No output is tied to constant 0.

FETCH:
- When `pgm$read__RDY & dec__RDY`: latch op, arithOp, src1, src2 and dst; go to EXEC.

EXEC:
- When `rf$read__RDY & exec$basicExec__RDY`: latch data, addr, nextPC, and `rf$read2` as the store data.
- Next state by op:
  - ARITH → WB
  - LOAD or STORE → MEM_REQ
  - JUMP → FETCH, with `pc <= nextPC` (retire)

MEM_REQ:
- `dmem$request__ENA` = 1 and `write_en` = (op == STORE), with the latched addr and data.
- On `dmem$request__RDY`: STORE → FETCH with `pc <= nextPC` (retire); LOAD → MEM_WAIT.

MEM_WAIT:
- On `dmem$response__ENA`: latch `dmem$response` as the writeback value; go to WB.

WB:
- If dst ≠ 0: assert `rf$write__ENA`; on `rf$write__RDY`, set `pc <= nextPC` and go to FETCH.
- If dst == 0: no write enable; set `pc <= nextPC` and go to FETCH in the same cycle.

Arithmetic and boundary rules:
- The PC is exactly DATA_WIDTH bits, so `nextPC` wraps modulo 2^DATA_WIDTH with no special handling.
- `dmem$response__ENA` outside MEM_WAIT is ignored and dropped.
- Any `__RDY` low holds the current state. All latched values stay stable while stalled.
- Reset asserted mid-instruction aborts that instruction. No request is re-issued after reset.
- Reset values:
  - state FETCH, `pc` = RESET_PC
  - all `__ENA` outputs 0, `write_en` 0
  - all latched fields 0, so every data output reads 0

## Timing
- Each transition happens on the `CLK` edge where the state's condition holds.
- Minimum cycles per instruction, all RDYs high:
  - JUMP 2
  - ARITH 3
  - STORE 3
  - LOAD 4 plus response latency, in cycles after the request handshake
- `rf$write__ENA` and `dmem$request__ENA` are high for exactly the cycles spent in WB and MEM_REQ respectively.
- A handshake completes on the edge where ENA and RDY are both high.
- `pgm$read$pc` shows the new PC in the first cycle after retire.

## Configuration
- `MULTI_CYCLE_PROC_INSTRET_EN`
- Defined:
  - adds output `instret` (32 bits), reset to 0
  - increments by 1 on every retire edge (JUMP, STORE, WB exit) and wraps at 2^32
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset with RESET_PC=0x100, then release → `pgm$read$pc`=0x100, all ENAs 0, state FETCH.
- ARITH, dst=3, exec data=0x55, nextPC=0x104, all RDYs high → `rf$write__ENA` high on cycle 3 with regnum 3 and regval 0x55; pc=0x104 on cycle 4.
- LOAD, addr=0x40, response 0xDEAD delivered 5 cycles after the request handshake → one request with write_en=0 and addr 0x40; then register write of 0xDEAD.
- STORE with `rf$read2`=0x77 and `dmem$request__RDY` held low 3 cycles → ENA held 4 cycles with stable addr and data; no register write.
- ARITH with dst=0 → `rf$write__ENA` never asserts; PC advances. JUMP with nextPC=0xFFFFFFFC then ARITH with nextPC=0 → PC wraps to 0.
- Stray `dmem$response__ENA` during FETCH, then `nRST` pulsed during MEM_WAIT → stray response ignored; core restarts at RESET_PC; `instret`=0 when the macro is defined.
